// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one I2C master between two requesters.
// Round-robin arbitration, one-cycle enable pulse, start/run watchdogs,
// and per-port read data plus a completion status on the done pulse.
module i2c_req_arbiter #(
  parameter int START_WAIT  = 8,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  // requester port 0
  input  logic       req0,
  input  logic       mode0,
  input  logic [6:0] addr0,
  input  logic [7:0] wdata0,
  input  logic       stop0,
  output logic       done0,
  output logic [7:0] rdata0,
  // requester port 1
  input  logic       req1,
  input  logic       mode1,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata1,
  input  logic       stop1,
  output logic       done1,
  output logic [7:0] rdata1,
  // shared completion info
  output logic [1:0] status,
  output logic [1:0] grant,
  // I2C master side
  output logic       m_enable,
  output logic       m_mode,
  output logic [6:0] m_slave_addr,
  output logic [7:0] m_data,
  output logic       m_stop,
  input  logic [7:0] m_recv_buf,
  input  logic       m_busy,
  input  logic       m_error
);

  // One counter serves both watchdogs; START_WAIT is assumed <= RUN_TIMEOUT.
  localparam int CNT_W = $clog2(RUN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_NACK     = 2'b01,
    ST_START_TO = 2'b10,
    ST_RUN_TO   = 2'b11
  } status_e;

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;     // port served most recently
  logic             mode_q, mode_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rdata0_q, rdata0_d;
  logic [7:0]       rdata1_q, rdata1_d;

  // Port 1 wins if it is the only requester, or if both request and
  // port 0 was served last.
  logic pick1;
  assign pick1 = req1 & (~req0 | ~last_q);

  // State register: async reset aborts any transaction on the spot.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      mode_q   <= 1'b0;
      addr_q   <= 7'd0;
      data_q   <= 8'd0;
      stop_q   <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= 8'd0;
      rdata1_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      stop_q   <= stop_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state logic: arbitration, launch sequencing and watchdogs.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    status_d = status_q;
    grant_d  = grant_q;
    last_d   = last_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    data_d   = data_q;
    stop_d   = stop_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      S_IDLE: begin
        // A busy master here is foreign or stale activity: never grant.
        if ((req0 || req1) && !m_busy) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          mode_d  = pick1 ? mode1  : mode0;
          addr_d  = pick1 ? addr1  : addr0;
          data_d  = pick1 ? wdata1 : wdata0;
          stop_d  = pick1 ? stop1  : stop0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (m_busy) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_q == START_LAST) begin
          status_d = ST_START_TO;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!m_busy) begin
          status_d = m_error ? ST_NACK : ST_OK;
          if (mode_q) begin
            if (grant_q[1]) rdata1_d = m_recv_buf;
            else            rdata0_d = m_recv_buf;
          end
          state_d = S_DONE;
        end else if (cnt_q == RUN_LAST) begin
          status_d = ST_RUN_TO;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_enable     = (state_q == S_LAUNCH);
  assign done0        = (state_q == S_DONE) & grant_q[0];
  assign done1        = (state_q == S_DONE) & grant_q[1];
  assign status       = status_q;
  assign grant        = grant_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign m_mode       = mode_q;
  assign m_slave_addr = addr_q;
  assign m_data       = data_q;
  assign m_stop       = stop_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Testbench for i2c_req_arbiter: directed stimulus, a small I2C master
// model, and a scoreboard drained by a monitor on every done pulse.
module tb_i2c_req_arbiter;

  localparam int START_WAIT  = 8;
  localparam int RUN_TIMEOUT = 64;
  localparam int REF_NONE = 0;
  localparam int REF_FALL = 1;   // latency measured from m_enable fall
  localparam int REF_BUSY = 2;   // latency measured from model raising busy

  logic       clk, reset;
  logic       req0, mode0, stop0, done0;
  logic [6:0] addr0;
  logic [7:0] wdata0, rdata0;
  logic       req1, mode1, stop1, done1;
  logic [6:0] addr1;
  logic [7:0] wdata1, rdata1;
  logic [1:0] status, grant;
  logic       m_enable, m_mode, m_stop, m_busy, m_error;
  logic [6:0] m_slave_addr;
  logic [7:0] m_data, m_recv_buf;

  i2c_req_arbiter #(.START_WAIT(START_WAIT), .RUN_TIMEOUT(RUN_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .mode0(mode0), .addr0(addr0), .wdata0(wdata0), .stop0(stop0),
    .done0(done0), .rdata0(rdata0),
    .req1(req1), .mode1(mode1), .addr1(addr1), .wdata1(wdata1), .stop1(stop1),
    .done1(done1), .rdata1(rdata1),
    .status(status), .grant(grant),
    .m_enable(m_enable), .m_mode(m_mode), .m_slave_addr(m_slave_addr),
    .m_data(m_data), .m_stop(m_stop),
    .m_recv_buf(m_recv_buf), .m_busy(m_busy), .m_error(m_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic       port;
    logic [1:0] status;
    logic [7:0] rd0;
    logic [7:0] rd1;
    int         lat;
    int         lat_ref;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input logic port, input logic [1:0] st, input logic [7:0] rd0,
                      input logic [7:0] rd1, input int lat, input int lat_ref);
    exp_t e;
    e.port = port; e.status = st; e.rd0 = rd0; e.rd1 = rd1;
    e.lat = lat; e.lat_ref = lat_ref;
    sb_q.push_back(e);
  endtask

  // Master model configuration
  int         cfg_delay = 2;     // negedges after enable fall before busy; <0 = never
  int         cfg_len   = 10;    // busy length in cycles; <=0 = hold until released
  logic [7:0] cfg_rbuf  = 8'h00;
  logic       cfg_err   = 1'b0;
  logic       release_busy = 1'b0;
  int         fall_cyc = 0;
  int         busy_cyc = 0;

  // I2C master model: reacts to each enable pulse.
  initial begin
    m_busy = 1'b0; m_error = 1'b0; m_recv_buf = 8'h00;
    forever begin
      @(negedge clk);
      if (m_enable === 1'b1) begin
        @(negedge clk);
        check("enable_one_cycle", 32'(m_enable), 32'(0));
        fall_cyc = cyc;
        if (cfg_delay >= 0) begin
          repeat (cfg_delay) @(negedge clk);
          m_busy = 1'b1; m_error = 1'b0; m_recv_buf = 8'hFF; busy_cyc = cyc;
          if (cfg_len > 0) begin
            repeat (cfg_len - 1) @(negedge clk);
            m_recv_buf = cfg_rbuf; m_error = cfg_err;
            @(negedge clk);
            m_busy = 1'b0;
          end else begin
            wait (reset || release_busy);
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: one-hot grant, field stability, and scoreboard on done.
  initial begin
    exp_t       e;
    logic       have_snap;
    logic [16:0] snap;
    have_snap = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("grant_onehot", 32'($countones(grant) <= 1), 32'(1));
        if (done0 || done1) begin
          check("done_onehot", 32'(done0 & done1), 32'(0));
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done: done0=%0b done1=%0b, expected no done (t=%0t)",
                     done0, done1, $time);
          end else begin
            e = sb_q.pop_front();
            check("done_port", 32'(done1), 32'(e.port));
            check("status", 32'(status), 32'(e.status));
            check("rdata0", 32'(rdata0), 32'(e.rd0));
            check("rdata1", 32'(rdata1), 32'(e.rd1));
            if (e.lat_ref == REF_FALL) check("start_wd_latency", 32'(cyc - fall_cyc), 32'(e.lat));
            if (e.lat_ref == REF_BUSY) check("run_wd_latency", 32'(cyc - busy_cyc), 32'(e.lat));
          end
        end
        if (grant == 2'b00) have_snap = 1'b0;
        else if (have_snap)
          check("m_fields_stable", 32'({m_mode, m_slave_addr, m_data, m_stop}), 32'(snap));
        if (m_enable) begin
          snap = {m_mode, m_slave_addr, m_data, m_stop};
          have_snap = 1'b1;
        end
      end else begin
        have_snap = 1'b0;
      end
    end
  end

  task automatic start_req(input int port, input logic mode, input logic [6:0] addr,
                           input logic [7:0] wd, input logic stop);
    if (port == 0) begin
      mode0 = mode; addr0 = addr; wdata0 = wd; stop0 = stop; req0 = 1'b1;
    end else begin
      mode1 = mode; addr1 = addr; wdata1 = wd; stop1 = stop; req1 = 1'b1;
    end
  endtask

  task automatic drop_on_grant(input int port);
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant[port]) break;
    end
    check("granted", 32'(grant[port]), 32'(1));
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("sb_drained", 32'(sb_q.size()), 32'(0));
    @(negedge clk);
  endtask

  task automatic cfg(input int d, input int len, input logic [7:0] rb, input logic err);
    cfg_delay = d; cfg_len = len; cfg_rbuf = rb; cfg_err = err;
  endtask

  // Hard stop if anything hangs beyond every bounded wait.
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int seen;
    reset = 1'b1;
    req0 = 0; mode0 = 0; addr0 = 0; wdata0 = 0; stop0 = 0;
    req1 = 0; mode1 = 0; addr1 = 0; wdata1 = 0; stop1 = 0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_done", 32'({done0, done1, m_enable}), 32'(0));
    check("rst_status", 32'(status), 32'(0));
    check("rst_rdata", 32'({rdata0, rdata1}), 32'(0));
    check("rst_m_fields", 32'({m_mode, m_slave_addr, m_data, m_stop}), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single write on port 0; fields changed and req dropped after grant.
    cfg(2, 40, 8'h00, 1'b0);
    push(1'b0, 2'b00, 8'h00, 8'h00, 0, REF_NONE);
    start_req(0, 1'b0, 7'h50, 8'hA5, 1'b1);
    @(negedge clk);
    check("wr_enable_rise", 32'(m_enable), 32'(1));
    check("wr_grant", 32'(grant), 32'(2'b01));
    check("wr_addr", 32'(m_slave_addr), 32'(7'h50));
    check("wr_data", 32'(m_data), 32'(8'hA5));
    check("wr_mode_stop", 32'({m_mode, m_stop}), 32'(2'b01));
    req0 = 1'b0; addr0 = 7'h11; wdata0 = 8'h00; stop0 = 1'b0;
    wait_idle(200);
    check("wr_grant_idle", 32'(grant), 32'(0));

    // Read on port 1.
    cfg(3, 30, 8'h7E, 1'b0);
    push(1'b1, 2'b00, 8'h00, 8'h7E, 0, REF_NONE);
    start_req(1, 1'b1, 7'h3C, 8'h00, 1'b1);
    drop_on_grant(1);
    wait_idle(200);

    // Contention: both held for four transactions, expected 0,1,0,1.
    cfg(1, 12, 8'h00, 1'b0);
    push(1'b0, 2'b00, 8'h00, 8'h7E, 0, REF_NONE);
    push(1'b1, 2'b00, 8'h00, 8'h7E, 0, REF_NONE);
    push(1'b0, 2'b00, 8'h00, 8'h7E, 0, REF_NONE);
    push(1'b1, 2'b00, 8'h00, 8'h7E, 0, REF_NONE);
    start_req(0, 1'b0, 7'h10, 8'h01, 1'b0);
    start_req(1, 1'b0, 7'h20, 8'h02, 1'b1);
    seen = 0;
    for (int i = 0; i < 400 && seen < 4; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        seen++;
        if (seen == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("contention_count", 32'(seen), 32'(4));
    wait_idle(20);

    // NACK on port 0, then a normal read on port 0.
    cfg(2, 20, 8'h00, 1'b1);
    push(1'b0, 2'b01, 8'h00, 8'h7E, 0, REF_NONE);
    start_req(0, 1'b0, 7'h44, 8'h12, 1'b1);
    drop_on_grant(0);
    wait_idle(200);
    cfg(2, 20, 8'h5A, 1'b0);
    push(1'b0, 2'b00, 8'h5A, 8'h7E, 0, REF_NONE);
    start_req(0, 1'b1, 7'h44, 8'h00, 1'b1);
    drop_on_grant(0);
    wait_idle(200);

    // Start watchdog: busy never rises.
    cfg(-1, 0, 8'h00, 1'b0);
    push(1'b0, 2'b10, 8'h5A, 8'h7E, START_WAIT, REF_FALL);
    start_req(0, 1'b0, 7'h55, 8'h66, 1'b1);
    drop_on_grant(0);
    wait_idle(100);

    // Run watchdog on a read: busy held; rdata0 must stay 0x5A.
    // Busy is sampled at the next edge, then RUN lasts RUN_TIMEOUT cycles.
    cfg(2, 0, 8'h00, 1'b0);
    push(1'b0, 2'b11, 8'h5A, 8'h7E, RUN_TIMEOUT + 1, REF_BUSY);
    start_req(0, 1'b1, 7'h66, 8'h00, 1'b1);
    drop_on_grant(0);
    wait_idle(300);

    // Master still busy in IDLE: no grant. Port 0 drops before grant.
    start_req(0, 1'b0, 7'h01, 8'h01, 1'b0);
    start_req(1, 1'b0, 7'h2B, 8'hC3, 1'b1);
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_idle_no_grant", 32'({grant, m_enable}), 32'(0));
    cfg(2, 10, 8'h00, 1'b0);
    push(1'b1, 2'b00, 8'h5A, 8'h7E, 0, REF_NONE);
    release_busy = 1'b1;
    @(negedge clk);
    release_busy = 1'b0;
    drop_on_grant(1);
    wait_idle(200);

    // Reset during RUN: immediate clear, no done pulse.
    cfg(2, 0, 8'h00, 1'b0);
    start_req(1, 1'b0, 7'h22, 8'h33, 1'b1);
    drop_on_grant(1);
    for (int i = 0; i < 20 && !m_busy; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("grant_before_reset", 32'(grant), 32'(2'b10));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_grant_en", 32'({grant, m_enable, done0, done1}), 32'(0));
    check("mid_rst_rdata", 32'({rdata0, rdata1}), 32'(0));
    check("mid_rst_status", 32'(status), 32'(0));
    check("mid_rst_m_fields", 32'({m_mode, m_slave_addr, m_data, m_stop}), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cfg(2, 20, 8'h99, 1'b0);
    push(1'b1, 2'b00, 8'h00, 8'h99, 0, REF_NONE);
    start_req(1, 1'b1, 7'h3C, 8'h00, 1'b0);
    drop_on_grant(1);
    wait_idle(200);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one I2C_MASTER between two independent requesters (port 0, port 1).
- Arbitrates round-robin, latches the winner's command onto the master's enable/mode/slave_addr/data/stop inputs, and sequences the enable pulse.
- Tracks master busy, adds start and run watchdogs, and returns read data plus a completion status to the granted requester.
- Sits directly between system-side requesters and the I2C_MASTER instance.

Parameters:
- START_WAIT, 8: max cycles after m_enable falls for m_busy to rise before declaring a start timeout.
- RUN_TIMEOUT, 4096: max cycles m_busy may stay high before declaring a run timeout (counter width is clog2(RUN_TIMEOUT+1)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request level; held high with fields stable until doneN.
- mode0 / mode1  in  1  0 = write, 1 = read.
- addr0 / addr1  in  7  slave address.
- wdata0 / wdata1  in  8  write byte.
- stop0 / stop1  in  1  forwarded to m_stop.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  8  read byte, valid from doneN, held until the next doneN.
- status  out  2  valid with either done: 00 ok, 01 slave NACK (m_error), 10 start timeout, 11 run timeout.
- grant  out  2  one-hot owner of the master, 00 when idle.
- m_enable  out  1  to master enable.
- m_mode  out  1  to master mode.
- m_slave_addr  out  7  to master slave_addr.
- m_data  out  8  to master data.
- m_stop  out  1  to master stop.
- m_recv_buf  in  8  from master recv_buf.
- m_busy  in  1  from master busy.
- m_error  in  1  from master error.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Round-robin pointer favours port 0 first.
  - Counters cleared.
  - Reset asserted mid-transaction aborts immediately: no done pulse, m_enable forced to 0.
- IDLE:
  - If any reqN and m_busy=0, pick the winner:
    - Only one requesting: that one wins.
    - Both requesting: the port not granted last wins.
  - Register grant and m_* fields from the winner, go to LAUNCH.
  - If m_busy=1 in IDLE (foreign or stale activity), do not grant; stay in IDLE.
- LAUNCH:
  - m_enable=1 for exactly one cycle, then WAIT_BUSY.
  - m_enable rises 1 cycle after reqN is first sampled in IDLE.
  - The master only advances after enable falls, so the pulse must not be longer.
- WAIT_BUSY:
  - Count cycles.
  - m_busy=1 -> RUN, clear counter.
  - Count reaches START_WAIT with m_busy still 0 -> DONE with status 10.
- RUN:
  - Count cycles while m_busy=1.
  - m_busy falls -> DONE: status 01 if m_error=1, else 00; capture m_recv_buf into rdataN if m_mode=1.
  - Count reaches RUN_TIMEOUT -> DONE with status 11, rdataN unchanged.
- DONE:
  - doneN=1 and status driven for one cycle.
  - Update the round-robin pointer to the served port; clear grant; return to IDLE.
  - status holds its value until the next done.
- Write transactions leave rdataN unchanged.
- m_* fields are held stable from LAUNCH until DONE, regardless of requester activity.
- A reqN dropped after grant does not abort: the transaction completes and doneN still pulses.
- A reqN dropped before grant is ignored.
- A reqN still high in the cycle after doneN is treated as a new request; it is re-arbitrated against the other port, and the other port wins if it is pending.
- Back-to-back: minimum of 1 IDLE cycle between DONE and the next LAUNCH.

Test Plan:
- Single write: req0, mode0=0, addr0=0x50, wdata0=0xA5, stop0=1; master model busy for 40 cycles, m_error=0 -> m_enable one pulse 1 cycle after req0; m_slave_addr=0x50, m_data=0xA5 held stable; done0 pulse with status 00; grant back to 00.
- Read: req1, mode1=1, addr1=0x3C; model returns m_recv_buf=0x7E at busy fall -> done1 pulse, rdata1=0x7E, status 00; rdata0 unchanged.
- Contention: req0 and req1 rise in the same cycle, both held -> order port0, port1, port0, port1 over 4 transactions; never two grant bits set at once.
- NACK: model sets m_error=1 before busy falls -> status 01 with done0; the next request from port 0 is served normally.
- Watchdogs:
  - Model never raises busy -> done0 with status 10 exactly START_WAIT cycles after m_enable falls.
  - Model holds busy forever, RUN_TIMEOUT=64 -> done0 with status 11 after 64 busy cycles.
- Reset mid-RUN: assert reset during busy -> all outputs 0 asynchronously, no done pulse; after release and master idle, a new req1 is served.
